uart_tx_fifo: RTL
=================

# uart_tx_fifo

- Byte buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from a host write port, stores them in a circular FIFO, and launches them one at a time on the transmitter's `tx_dv`/`tx_data_in` handshake.
- Holds off the next launch until the current frame completes (`tx_done`) and the line is idle (`!tx_active`).
- Lets software queue bursts without polling the serializer.

## Interface

- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `AW`, 4: pointer width, must equal log2(`DEPTH`).
- `clk` in 1: system clock; same clock as `UART_TX`.
- `rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `wr_en` in 1: host write strobe; one byte per cycle.
- `wr_data` in 8: byte to enqueue.
- `full` out 1: registered; high when count == `DEPTH`.
- `empty` out 1: registered; high when count == 0.
- `count` out AW+1: registered occupancy, 0..`DEPTH`.
- `tx_dv` out 1: one-cycle launch pulse to `UART_TX.tx_dv`.
- `tx_data` out 8: byte to `UART_TX.tx_data_in`; valid while `tx_dv`=1 and held until the next launch.
- `tx_active` in 1: from `UART_TX.tx_active`.
- `tx_done` in 1: from `UART_TX.tx_done`; one-cycle pulse at the end of the stop bit.
- `overflow` out 1: sticky overflow flag; present only with `UART_TX_FIFO_OVF_EN`.

## Operation

- Storage: `DEPTH` x 8 register array, with write pointer `wp`, read pointer `rp` (AW bits each), and `count`.
- Pointers wrap from `DEPTH`-1 to 0 by natural AW-bit overflow.
- Push: a write is accepted at an edge when `wr_en`=1 and `full`=0 at that edge.
  - `mem[wp]` <= `wr_data`, then `wp`++.
  - A write while `full`=1 is dropped, even if a pop occurs on the same edge.
- Pop: happens only on a launch.
- FSM states:
  - IDLE: if `empty`=0 and `tx_active`=0 at an edge, then `tx_dv`<=1, `tx_data`<=`mem[rp]`, `rp`++, and go to WAIT.
  - WAIT: `tx_dv`<=0. Stay until `tx_done`=1 is sampled, then go to IDLE.
- Simultaneous push and pop: `count` unchanged; both pointers advance.
- Empty FIFO: no pop; `tx_dv` stays 0.
- A push to an empty FIFO in the same cycle as an IDLE check is not visible until the next edge. There is no bypass path.
- Reset (`rst`=1 at an edge), including mid-frame:
  - `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `tx_dv`=0, `tx_data`=8'h00, FSM=IDLE, `overflow`=0.
  - Stored data is discarded; the array itself is not cleared.
  - A frame already in `UART_TX` finishes independently. The FIFO relaunches only once `tx_active`=0.
- `tx_done` received in IDLE is ignored.

## Timing

- Write-to-launch latency, empty FIFO and idle line: write accepted at edge k; `count`=1 after k; `tx_dv`=1 during cycle k+1..k+2; `count`=0 after k+1.
- Back-to-back launch: `tx_done` sampled at edge m puts the FSM in IDLE; the next `tx_dv` rises after edge m+1, provided `tx_active`=0 at m+1.
- Maximum one launch per frame. Sustained throughput equals the UART rate.
- `full`, `empty`, and `count` update on the same edge as the push/pop that changes them.

## Configuration

- `UART_TX_FIFO_OVF_EN` defined:
  - `overflow` port exists.
  - It is set on the edge a write is dropped (`wr_en`=1 and `full`=1).
  - It stays set until `rst`.
- `UART_TX_FIFO_OVF_EN` undefined:
  - No `overflow` port and no flag register.
  - Dropped writes are silent; all other behaviour is identical.

## Test plan

- Single byte: after reset, write 8'h69 with `UART_TX` and `UART_RX` attached (cpb=217) -> `tx_dv` pulses once, `tx_data`=8'h69; RX `rx_dv` pulses with `rx_data_out`=8'h69; `empty`=1 afterward.
- Burst: write 8'h01..8'h05 on consecutive cycles -> `count` peaks at 4 (the first byte pops on the second write edge); RX receives 01,02,03,04,05 in order; exactly five `tx_dv` pulses, each after the preceding `tx_done`.
- Full/overflow with `DEPTH`=4 and `tx_active` held 1: write 6 bytes -> `count`=4, `full`=1; bytes 5–6 dropped; `overflow`=1 when the macro is on. Release `tx_active` -> first four bytes sent.
- Wrap-around, `DEPTH`=4: 10 writes spaced so the FIFO never exceeds 3 entries -> all 10 bytes received in order; `wp`/`rp` wrap twice.
- Simultaneous push/pop: `count`=2 and a write lands on the launch edge -> `count` stays 2; data order is preserved.
- Reset mid-frame: assert `rst` for one cycle while a frame is active and 3 bytes are queued -> outputs hit their reset values; the in-flight frame completes on the line; no further `tx_dv` until a new write.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Bundles the host write port and the UART_TX launch handshake of
//   uart_tx_fifo.
//   Host side   : wr_en, wr_data (to FIFO); full, empty, count (from FIFO)
//   UART_TX side: tx_dv, tx_data (from FIFO); tx_active, tx_done (to FIFO)
//   overflow    : sticky dropped-write flag, present only when
//                 UART_TX_FIFO_OVF_EN is defined.
//   slave modport  : used by the FIFO itself.
//   master modport : used by whatever drives the host port and the UART status.
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          tx_dv;
  logic [7:0]    tx_data;
  logic          tx_active;
  logic          tx_done;
`ifdef UART_TX_FIFO_OVF_EN
  logic          overflow;
`endif

  modport slave (
    input  wr_en, wr_data, tx_active, tx_done,
`ifdef UART_TX_FIFO_OVF_EN
    output overflow,
`endif
    output full, empty, count, tx_dv, tx_data
  );

  modport master (
    output wr_en, wr_data, tx_active, tx_done,
`ifdef UART_TX_FIFO_OVF_EN
    input  overflow,
`endif
    input  full, empty, count, tx_dv, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Circular byte FIFO in front of UART_TX. Host writes are queued and
//   launched one at a time with a single-cycle tx_dv pulse; the next launch
//   waits for tx_done of the current frame and an idle line (!tx_active).
//   Ports:
//     clk  - system clock, shared with UART_TX
//     rst  - synchronous active-high reset
//     bus  - uart_tx_fifo_if.slave (host write port + UART_TX handshake)
//   Parameters: DEPTH (power of two, 2..256), AW = log2(DEPTH).
//   Optional feature: define UART_TX_FIFO_OVF_EN to get the sticky
//   bus.overflow flag, set whenever a write is dropped because the FIFO
//   is full.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready to launch the head byte once the FIFO is non-empty and
//         | the line is idle
//   WAIT  | a byte has been launched; waiting for tx_done from UART_TX
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_fifo_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic            push;
  logic            pop;
  logic [AW:0]     next_count;

  // Flags are registered, so a write that lands in the same cycle as an
  // IDLE check on an empty FIFO is only seen at the following edge.
  assign push = bus.wr_en && !bus.full;
  assign pop  = (state == IDLE) && !bus.empty && !bus.tx_active;

  always_comb begin
    next_count = bus.count;
    case ({push, pop})
      2'b10:   next_count = bus.count + 1'b1;
      2'b01:   next_count = bus.count - 1'b1;
      default: next_count = bus.count;
    endcase
  end

  // Storage is deliberately not reset; reset only discards it via pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wp          <= '0;
      rp          <= '0;
      bus.count   <= '0;
      bus.empty   <= 1'b1;
      bus.full    <= 1'b0;
      bus.tx_dv   <= 1'b0;
      bus.tx_data <= 8'h00;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      bus.count <= next_count;
      bus.empty <= (next_count == '0);
      bus.full  <= (next_count == (AW+1)'(DEPTH));

      case (state)
        IDLE: begin
          bus.tx_dv <= 1'b0;
          if (pop) begin
            bus.tx_dv   <= 1'b1;
            bus.tx_data <= mem[rp];
            rp          <= rp + 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          bus.tx_dv <= 1'b0;
          if (bus.tx_done) begin
            state <= IDLE;
          end
        end
        default: begin
          bus.tx_dv <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.overflow <= 1'b0;
    end else if (bus.wr_en && bus.full) begin
      bus.overflow <= 1'b1;
    end
  end
`endif

endmodule
